// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: takes one padded 512-bit block and streams W[0..ROUNDS-1],
// one 32-bit word per handshake, expanding W[16..] through a registered 16-word window.
module sha256_msg_sched #(
  parameter int ROUNDS = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [31:0]      w_out,
  output logic [IDX_W-1:0] w_idx,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      win_q [16];
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             advance;
  logic             last_word;
  logic [31:0]      w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Window holds W[t..t+15] with W[t] in slot 0, so W[t+16] needs slots 0, 1, 9 and 14.
  assign w_next    = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  assign last_word = (idx_q == IDX_W'(ROUNDS - 1));

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d   = state_q;
    blk_ready = (state_q == IDLE);
    w_valid   = (state_q == EMIT);
    busy      = (state_q != IDLE);
    accept    = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          accept  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (w_ready) begin
          advance = 1'b1;
          if (last_word) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let the window shift read half-updated slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the window is only 16 words and must read as zero after reset, so it is reset
  // like ordinary flops rather than treated as an unreset memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      idx_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) win_q[i] <= blk_data[511 - 32*i -: 32];
      idx_q <= '0;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) win_q[i] <= win_q[i + 1];
      win_q[15] <= w_next;
      // Index saturates on the final word; the next accept clears it.
      if (!last_word) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign w_out = win_q[0];
  assign w_idx = idx_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: directed FIPS "abc" cases plus random blocks
// compared against a plain-arithmetic reference of the SHA-256 message schedule.
module tb_sha256_msg_sched;

  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;

  logic             clk;
  logic             rst_n;
  logic             blk_valid;
  logic             blk_ready;
  logic [511:0]     blk_data;
  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w_out;
  logic [IDX_W-1:0] w_idx;
  logic             busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_w [ROUNDS];
  logic [31:0] got_w [ROUNDS];

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  sha256_msg_sched #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .w_idx     (w_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the FIPS 180-4 recurrence.
  task automatic compute_sched(input logic [511:0] b);
    for (int j = 0; j < ROUNDS; j++) begin
      if (j < 16) begin
        exp_w[j] = b[511 - 32*j -: 32];
      end else begin
        logic [31:0] a, c;
        a = rotr(exp_w[j-15], 7) ^ rotr(exp_w[j-15], 18) ^ (exp_w[j-15] >> 3);
        c = rotr(exp_w[j-2], 17) ^ rotr(exp_w[j-2], 19) ^ (exp_w[j-2] >> 10);
        exp_w[j] = c + exp_w[j-7] + a + exp_w[j-16];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a block and check the first word appears right after the accepting edge.
  task automatic accept_block(input logic [511:0] b);
    int c = 0;
    while (!blk_ready && c < 200) begin
      tick();
      c++;
    end
    if (!blk_ready) check("accept_timeout", 64'(blk_ready), 64'd1);
    compute_sched(b);
    blk_data  = b;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    check("first_valid", 64'(w_valid), 64'd1);
    check("first_idx", 64'(w_idx), 64'd0);
    check("first_busy", 64'(busy), 64'd1);
  endtask

  // mode 0: always ready, 1: 3-cycle stall at index 20, 2: random ready.
  task automatic drain(input int mode, output int valid_cycles);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    valid_cycles = 0;
    while (k < ROUNDS && cyc < 2000) begin
      case (mode)
        0:       w_ready = 1'b1;
        1:       begin
                   w_ready = !(k == 20 && stall < 3);
                   if (!w_ready) stall++;
                 end
        default: w_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (w_valid) valid_cycles++;
      check("emit_valid", 64'(w_valid), 64'd1);
      check("emit_blk_ready", 64'(blk_ready), 64'd0);
      if (mode == 1 && !w_ready) begin
        check("stall_idx", 64'(w_idx), 64'd20);
        check("stall_word", 64'(w_out), 64'(exp_w[20]));
      end
      if (w_valid && w_ready) begin
        check($sformatf("idx_%0d", k), 64'(w_idx), 64'(k));
        check($sformatf("w_%0d", k), 64'(w_out), 64'(exp_w[k]));
        got_w[k] = w_out;
        k++;
      end
      tick();
      cyc++;
    end
    if (k < ROUNDS) check("drain_timeout", 64'(k), 64'(ROUNDS));
    w_ready = 1'b0;
    check("end_valid", 64'(w_valid), 64'd0);
    check("end_blk_ready", 64'(blk_ready), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int vc;
    logic [511:0] blk2;
    logic [511:0] rblk;

    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b0;
    #2;
    check("rst_blk_ready", 64'(blk_ready), 64'd1);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_w_idx", 64'(w_idx), 64'd0);
    check("rst_w_out", 64'(w_out), 64'd0);
    #20;
    rst_n = 1'b1;
    tick();

    // 1: "abc" block, full throughput.
    accept_block(ABC_BLK);
    drain(0, vc);
    check("abc_valid_cycles", 64'(vc), 64'd64);
    check("abc_w0", 64'(got_w[0]), 64'h61626380);
    check("abc_w15", 64'(got_w[15]), 64'h00000018);
    check("abc_w16", 64'(got_w[16]), 64'h61626380);
    check("abc_w17", 64'(got_w[17]), 64'h000F0000);
    check("abc_w63", 64'(got_w[63]), 64'h12B1EDEB);
    tick();

    // 2: all-zero block.
    accept_block('0);
    drain(0, vc);
    check("zero_w40", 64'(got_w[40]), 64'd0);
    tick();

    // 3: backpressure at index 20.
    accept_block(ABC_BLK);
    drain(1, vc);
    check("bp_valid_cycles", 64'(vc), 64'd67);
    tick();

    // 4: second block offered continuously during EMIT.
    blk2 = '0;
    for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = 32'hA5000000 + 32'(i * 32'h01010101);
    accept_block(ABC_BLK);
    blk_valid = 1'b1;
    blk_data  = blk2;
    drain(0, vc);
    tick();
    blk_valid = 1'b0;
    compute_sched(blk2);
    check("b2_valid", 64'(w_valid), 64'd1);
    check("b2_idx", 64'(w_idx), 64'd0);
    check("b2_w0", 64'(w_out), 64'(exp_w[0]));
    drain(0, vc);
    tick();

    // 5: asynchronous reset mid-block.
    accept_block(ABC_BLK);
    w_ready = 1'b1;
    for (int c = 0; c < 100 && w_idx != 6'd30; c++) tick();
    check("pre_rst_idx", 64'(w_idx), 64'd30);
    rst_n = 1'b0;
    #1;
    check("arst_w_valid", 64'(w_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_blk_ready", 64'(blk_ready), 64'd1);
    check("arst_w_idx", 64'(w_idx), 64'd0);
    w_ready = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("post_rst_w_valid", 64'(w_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    accept_block(ABC_BLK);
    drain(0, vc);
    check("rst_abc_w63", 64'(got_w[63]), 64'h12B1EDEB);

    // 6: random blocks with random backpressure and random idle gaps.
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom();
      accept_block(rblk);
      drain(2, vc);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
